fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Sequencer for the program-counter unit and the instruction-memory port. It drives the PC unit's advance and branch-select controls (go, selPCsrc, branchIn). It issues one instruction-memory request per PC with a req/ack handshake and presents fetched words to decode with a valid/ready handshake. It also applies branch redirects, halts, and fetch timeouts. It sits between the PC register, instruction memory and the decode stage of the RISC-V core.

Parameters:
PC_WIDTH, 32, width of PC, memory address and branch target
TO_LIMIT, 255, maximum cycles a memory request may wait for ack before timeout (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
start  input  1  pulse: begin fetching from current PC (honoured only in IDLE)
halt  input  1  pulse: stop after the in-flight instruction is delivered
pc  input  PC_WIDTH  current PC from PC unit
pc_go  output  1  to PC unit go: PC updates at this clock edge
pc_sel  output  1  to PC unit selPCsrc: 1 = load pc_branch, 0 = PC+4
pc_branch  output  PC_WIDTH  to PC unit branchIn
imem_req  output  1  memory request, held until imem_ack
imem_addr  output  PC_WIDTH  request address (= pc while imem_req)
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  fetched word
instr_valid  output  1  instr/instr_pc valid for decode
instr  output  32  fetched instruction (registered)
instr_pc  output  PC_WIDTH  address of instr (registered)
instr_ready  input  1  decode accepts instr
branch_taken  input  1  pulse: redirect fetch to branch_target
branch_target  input  PC_WIDTH  redirect address
busy  output  1  state != IDLE
timeout_err  output  1  sticky: a request exceeded TO_LIMIT

Behaviour:
- Reset (async): state IDLE; instr, instr_pc, redirect-pending flag, redirect target, timeout counter, timeout_err all 0. Every output is 0, including combinational outputs. Reset mid-request drops imem_req immediately, and the in-flight request is abandoned.
- States: IDLE, FETCH, DELIVER.
- IDLE:
  - start -> FETCH; start also clears timeout_err and halt_pend.
  - branch_taken and halt are ignored.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Timeout counter increments each cycle imem_req=1 and imem_ack=0, and clears on ack.
  - On imem_ack with no redirect (pending flag clear and branch_taken=0): capture instr<=imem_rdata and instr_pc<=pc; pc_go=1, pc_sel=0; -> DELIVER.
  - On imem_ack with redirect (pending flag set or branch_taken=1 this cycle): discard the word; pc_go=1, pc_sel=1; clear the pending flag; stay FETCH. imem_req falls for one cycle.
  - branch_taken without ack: latch the pending flag and target; the request continues (never abandoned).
  - Counter reaching TO_LIMIT without ack: timeout_err<=1, clear the pending flag, -> IDLE. No pc_go.
- DELIVER:
  - instr_valid=1; instr and instr_pc stable; imem_req=0.
  - instr_ready=1, no redirect: -> FETCH, or -> IDLE if halt_pend.
  - branch_taken=1: pc_go=1, pc_sel=1; -> FETCH (IDLE if halt_pend). If instr_ready is also 1, the transfer counts as complete; decode squashes on branch_taken itself.
- pc_branch = branch_taken ? branch_target : latched target. It is driven combinationally so same-cycle redirects bypass the latch.
- Multiple branch_taken pulses before application: the latest target wins.
- halt: sets halt_pend in FETCH/DELIVER. The outstanding request always completes via ack or timeout, and the delivered word must be accepted before returning to IDLE. A redirect pending at halt is discarded on entering IDLE.
- Latency: memory ack in cycle N -> instr_valid in N+1 -> next imem_req in the cycle after the ready handshake. Maximum throughput is one instruction per 2 cycles with zero-wait memory.
- pc_go is asserted only as listed above. The PC never changes while the controller is in IDLE or waiting for ack/ready.
- Address arithmetic is performed by the PC unit and wraps modulo 2^PC_WIDTH; the controller does no addition.

Test Plan:
1. Reset, start; ack 2 cycles after req, rdata=0x00000013, pc=0 -> imem_req high 3 cycles at addr 0; pc_go=1, pc_sel=0 in the ack cycle; next cycle instr_valid=1, instr=0x13, instr_pc=0. With instr_ready=1, the next req is at addr 4.
2. Backpressure: instr_ready=0 for 5 cycles -> instr_valid held, instr/instr_pc constant, imem_req=0, pc_go=0. Ready on cycle 6 -> FETCH at pc+4.
3. branch_taken target 0x100 two cycles before ack -> the word at the old pc is never presented (instr_valid stays 0); in the ack cycle pc_go=1, pc_sel=1, pc_branch=0x100; next imem_addr=0x100.
4. branch_taken target 0x200 in the same cycle as imem_ack -> word dropped, pc_branch=0x200 bypassed; in DELIVER, branch_taken target 0x300 -> pc_go/pc_sel=1, next req at 0x300.
5. TO_LIMIT=8, ack never asserted -> after 8 waiting cycles timeout_err=1, imem_req=0, busy=0, no pc_go; start clears timeout_err and resumes at the unchanged pc.
6. halt while waiting for ack -> word delivered, then IDLE with no further req. Separately, rst_n low mid-FETCH -> imem_req=0 immediately and all outputs 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences PC advance, instruction-memory requests and decode hand-off,
// with branch redirects, halt and request timeout.
module fetch_ctrl #(
  parameter int PC_WIDTH = 32,
  parameter int TO_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                pc_go,
  output logic                pc_sel,
  output logic [PC_WIDTH-1:0] pc_branch,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  input  logic                instr_ready,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                busy,
  output logic                timeout_err
);
  localparam int CW = $clog2(TO_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;
  state_t state;
  logic redir_pend, halt_pend, gap;
  logic [PC_WIDTH-1:0] redir_tgt;
  logic [CW-1:0] to_cnt;
  logic fire, redirect, expired;
  assign busy = state != IDLE;
  // gap is the one idle cycle after a redirected ack while the PC loads the target
  assign imem_req = state == FETCH && !gap;
  assign imem_addr = imem_req ? pc : '0;
  assign instr_valid = state == DELIVER;
  assign fire = imem_req && imem_ack;
  assign redirect = redir_pend || branch_taken;
  assign expired = imem_req && !imem_ack && to_cnt == CW'(TO_LIMIT - 1);
  assign pc_go = fire || (instr_valid && branch_taken);
  assign pc_sel = pc_go && redirect;
  assign pc_branch = (busy && branch_taken) ? branch_target : redir_tgt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      instr <= '0;
      instr_pc <= '0;
      redir_pend <= 1'b0;
      redir_tgt <= '0;
      halt_pend <= 1'b0;
      gap <= 1'b0;
      to_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      gap <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          timeout_err <= 1'b0;
          halt_pend <= 1'b0;
        end
        FETCH: begin
          if (halt) halt_pend <= 1'b1;
          if (fire) begin
            to_cnt <= '0;
            if (redirect) begin
              redir_pend <= 1'b0;
              gap <= 1'b1;
            end else begin
              instr <= imem_rdata;
              instr_pc <= pc;
              state <= DELIVER;
            end
          end else begin
            if (branch_taken) begin
              redir_pend <= 1'b1;
              redir_tgt <= branch_target;
            end
            if (imem_req) to_cnt <= to_cnt + 1'b1;
            if (expired) begin
              timeout_err <= 1'b1;
              redir_pend <= 1'b0;
              to_cnt <= '0;
              state <= IDLE;
            end
          end
        end
        DELIVER: begin
          if (halt) halt_pend <= 1'b1;
          if (branch_taken || instr_ready) begin
            state <= halt_pend ? IDLE : FETCH;
            redir_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
